mano_bus_regfile: RTL and testbench

- Receiving end of the Mano basic-computer common bus.
- Takes the one-hot bus-source lines x[7:1] from the bus-control logic and encodes them to S2..S0.
- Drives the 16-bit common bus from the selected source and holds the processor registers that load from the bus: AR, PC, DR, IR, TR, OUTR.
- Also holds AC, which loads from the ALU, and supplies memory address and write data.

---
 rtl/mano_bus_regfile_pkg.sv | 34 +++
 rtl/mano_bus_regfile_if.sv | 25 ++
 rtl/mano_ctr_reg.sv | 24 ++
 rtl/mano_bus_regfile.sv | 113 +++++++++++
 tb/tb_mano_bus_regfile.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mano_bus_regfile_pkg.sv
// Shared widths, bus-source indices and select helpers for the Mano
// basic-computer common bus and its register file.
package mano_bus_regfile_pkg;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int OW = 8;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_AR   = 3'd1,
    SRC_PC   = 3'd2,
    SRC_DR   = 3'd3,
    SRC_AC   = 3'd4,
    SRC_IR   = 3'd5,
    SRC_TR   = 3'd6,
    SRC_MEM  = 3'd7
  } src_e;

  // Highest asserted line wins, so a contended bus still resolves deterministically.
  function automatic src_e encode_src(input logic [7:1] x);
    src_e s;
    s = SRC_NONE;
    for (int i = 1; i <= 7; i++) begin
      if (x[i]) s = src_e'(i[2:0]);
    end
    return s;
  endfunction

  function automatic logic multi_hot(input logic [7:1] x);
    return (x & (x - 7'd1)) != 7'd0;
  endfunction

endpackage

// File: rtl/mano_bus_regfile_if.sv
// Common-bus interface: source select and memory word in from bus control,
// bus value, encoded select, memory address and contention flag back out.
interface mano_bus_regfile_if #(
  parameter int AW = 12,
  parameter int DW = 16
);

  logic [7:0]    x;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] bus;
  logic [2:0]    sel;
  logic [AW-1:0] mem_addr;
  logic          bus_err;

  modport master (
    output x, mem_rdata,
    input  bus, sel, mem_addr, bus_err
  );

  modport slave (
    input  x, mem_rdata,
    output bus, sel, mem_addr, bus_err
  );

endinterface

// File: rtl/mano_ctr_reg.sv
// Parameterised-width register with clear, load and increment
// (clr > ld > inr), synchronous active-high reset.
module mano_ctr_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         inr,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: state updates use non-blocking assignment so every register in the
  // file samples the same pre-edge bus, which makes self-transfers the identity.
  always_ff @(posedge clk) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
    else if (inr) q <= q + W'(1);
  end

endmodule

// File: rtl/mano_bus_regfile.sv
// Receiving end of the Mano common bus: source encoder, bus mux, the
// processor registers that load from it, AC, and a sticky contention flag.
module mano_bus_regfile #(
  parameter int AW = mano_bus_regfile_pkg::AW,
  parameter int DW = mano_bus_regfile_pkg::DW,
  parameter int OW = mano_bus_regfile_pkg::OW
) (
  input  logic                clk,
  input  logic                reset,
  mano_bus_regfile_if.slave   bif,
  input  logic                ar_ld,
  input  logic                ar_inr,
  input  logic                ar_clr,
  input  logic                pc_ld,
  input  logic                pc_inr,
  input  logic                pc_clr,
  input  logic                dr_ld,
  input  logic                dr_inr,
  input  logic                dr_clr,
  input  logic                ac_ld,
  input  logic                ac_inr,
  input  logic                ac_clr,
  input  logic                tr_ld,
  input  logic                tr_inr,
  input  logic                tr_clr,
  input  logic                ir_ld,
  input  logic                outr_ld,
  input  logic [DW-1:0]       alu_out,
  output logic [AW-1:0]       ar,
  output logic [AW-1:0]       pc,
  output logic [DW-1:0]       dr,
  output logic [DW-1:0]       ac,
  output logic [DW-1:0]       ir,
  output logic [DW-1:0]       tr,
  output logic [OW-1:0]       outr
);

  import mano_bus_regfile_pkg::*;

  src_e          src;
  logic [DW-1:0] bus_w;
  logic          bus_err_q;
  logic          unused_x0;

  // x[0] is not a bus source.
  assign unused_x0 = bif.x[0];

  assign src     = encode_src(bif.x[7:1]);
  assign bif.sel = src;

  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; without it an uncovered select would infer a latch.
  always_comb begin
    bus_w = '0;
    case (src)
      SRC_AR:  bus_w = DW'(ar);
      SRC_PC:  bus_w = DW'(pc);
      SRC_DR:  bus_w = dr;
      SRC_AC:  bus_w = ac;
      SRC_IR:  bus_w = ir;
      SRC_TR:  bus_w = tr;
      SRC_MEM: bus_w = bif.mem_rdata;
      default: bus_w = '0;
    endcase
  end

  assign bif.bus      = bus_w;
  assign bif.mem_addr = ar;
  assign bif.bus_err  = bus_err_q;

  mano_ctr_reg #(.W(AW)) u_ar (
    .clk(clk), .reset(reset), .ld(ar_ld), .inr(ar_inr), .clr(ar_clr),
    .d(bus_w[AW-1:0]), .q(ar)
  );

  mano_ctr_reg #(.W(AW)) u_pc (
    .clk(clk), .reset(reset), .ld(pc_ld), .inr(pc_inr), .clr(pc_clr),
    .d(bus_w[AW-1:0]), .q(pc)
  );

  mano_ctr_reg #(.W(DW)) u_dr (
    .clk(clk), .reset(reset), .ld(dr_ld), .inr(dr_inr), .clr(dr_clr),
    .d(bus_w), .q(dr)
  );

  // AC is the one register fed from the ALU rather than the bus.
  mano_ctr_reg #(.W(DW)) u_ac (
    .clk(clk), .reset(reset), .ld(ac_ld), .inr(ac_inr), .clr(ac_clr),
    .d(alu_out), .q(ac)
  );

  mano_ctr_reg #(.W(DW)) u_tr (
    .clk(clk), .reset(reset), .ld(tr_ld), .inr(tr_inr), .clr(tr_clr),
    .d(bus_w), .q(tr)
  );

  mano_ctr_reg #(.W(DW)) u_ir (
    .clk(clk), .reset(reset), .ld(ir_ld), .inr(1'b0), .clr(1'b0),
    .d(bus_w), .q(ir)
  );

  mano_ctr_reg #(.W(OW)) u_outr (
    .clk(clk), .reset(reset), .ld(outr_ld), .inr(1'b0), .clr(1'b0),
    .d(bus_w[OW-1:0]), .q(outr)
  );

  // Sticky until reset: contention is a bus-control bug worth latching.
  always_ff @(posedge clk) begin
    if (reset)                        bus_err_q <= 1'b0;
    else if (multi_hot(bif.x[7:1]))   bus_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_mano_bus_regfile.sv
// Directed, table-driven bench for mano_bus_regfile with hand-computed
// expectations and a few hand-written reset/self-transfer sequences.
module tb_mano_bus_regfile;

  import mano_bus_regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, dr_clr;
  logic ac_ld, ac_inr, ac_clr, tr_ld, tr_inr, tr_clr, ir_ld, outr_ld;
  logic [15:0] alu_out;
  logic [11:0] ar, pc;
  logic [15:0] dr, ac, ir, tr;
  logic [7:0]  outr;

  mano_bus_regfile_if #(.AW(AW), .DW(DW)) bif();

  mano_bus_regfile dut (
    .clk(clk), .reset(reset), .bif(bif),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .dr_clr(dr_clr),
    .ac_ld(ac_ld), .ac_inr(ac_inr), .ac_clr(ac_clr),
    .tr_ld(tr_ld), .tr_inr(tr_inr), .tr_clr(tr_clr),
    .ir_ld(ir_ld), .outr_ld(outr_ld), .alu_out(alu_out),
    .ar(ar), .pc(pc), .dr(dr), .ac(ac), .ir(ir), .tr(tr), .outr(outr)
  );

  localparam logic [16:0] AR_LD   = 17'h00001, AR_INR = 17'h00002, AR_CLR = 17'h00004;
  localparam logic [16:0] PC_LD   = 17'h00008, PC_INR = 17'h00010, PC_CLR = 17'h00020;
  localparam logic [16:0] DR_LD   = 17'h00040, DR_INR = 17'h00080, DR_CLR = 17'h00100;
  localparam logic [16:0] AC_LD   = 17'h00200, AC_INR = 17'h00400, AC_CLR = 17'h00800;
  localparam logic [16:0] TR_LD   = 17'h01000, TR_INR = 17'h02000, TR_CLR = 17'h04000;
  localparam logic [16:0] IR_LD   = 17'h08000, OUTR_LD = 17'h10000;
  localparam logic [16:0] NO_CTL  = 17'h00000;

  typedef struct {
    logic [7:0]  x;
    logic [16:0] ctl;
    logic [15:0] mem;
    logic [15:0] alu;
    logic [2:0]  sel;
    logic [15:0] bus;
    logic [11:0] ar;
    logic [11:0] pc;
    logic [15:0] dr;
    logic [15:0] ac;
    logic [15:0] ir;
    logic [15:0] tr;
    logic [7:0]  outr;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] x, input logic [16:0] c,
                       input logic [15:0] mem, input logic [15:0] alu);
    bif.x         = x;
    bif.mem_rdata = mem;
    alu_out       = alu;
    {outr_ld, ir_ld, tr_clr, tr_inr, tr_ld, ac_clr, ac_inr, ac_ld,
     dr_clr, dr_inr, dr_ld, pc_clr, pc_inr, pc_ld, ar_clr, ar_inr, ar_ld} = c;
  endtask

  task automatic check_comb(input string tag, input logic [2:0] s, input logic [15:0] b);
    check({tag, ".sel"}, 32'(bif.sel), 32'(s));
    check({tag, ".bus"}, 32'(bif.bus), 32'(b));
  endtask

  task automatic check_regs(input string tag, input vec_t e);
    check({tag, ".ar"},       32'(ar),           32'(e.ar));
    check({tag, ".mem_addr"}, 32'(bif.mem_addr), 32'(e.ar));
    check({tag, ".pc"},       32'(pc),           32'(e.pc));
    check({tag, ".dr"},       32'(dr),           32'(e.dr));
    check({tag, ".ac"},       32'(ac),           32'(e.ac));
    check({tag, ".ir"},       32'(ir),           32'(e.ir));
    check({tag, ".tr"},       32'(tr),           32'(e.tr));
    check({tag, ".outr"},     32'(outr),         32'(e.outr));
    check({tag, ".bus_err"},  32'(bif.bus_err),  32'(e.err));
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.x, v.ctl, v.mem, v.alu);
    #1 check_comb(tag, v.sel, v.bus);
    @(posedge clk);
    #1 check_regs(tag, v);
  endtask

  vec_t zero_v;
  vec_t h;

  initial begin
    // x, ctl, mem, alu | sel, bus | ar, pc, dr, ac, ir, tr, outr, err (after edge)
    vecs.push_back('{8'h01, AC_LD, 16'h0000, 16'h0123, 3'd0, 16'h0000, 12'h000, 12'h000, 16'h0000, 16'h0123, 16'h0000, 16'h0000, 8'h00, 1'b0});
    vecs.push_back('{8'h10, PC_LD, 16'h0000, 16'h0000, 3'd4, 16'h0123, 12'h000, 12'h123, 16'h0000, 16'h0123, 16'h0000, 16'h0000, 8'h00, 1'b0});
    vecs.push_back('{8'h04, AR_LD, 16'h0000, 16'h0000, 3'd2, 16'h0123, 12'h123, 12'h123, 16'h0000, 16'h0123, 16'h0000, 16'h0000, 8'h00, 1'b0});
    vecs.push_back('{8'h80, IR_LD | DR_LD, 16'hB7A5, 16'h0000, 3'd7, 16'hB7A5, 12'h123, 12'h123, 16'hB7A5, 16'h0123, 16'hB7A5, 16'h0000, 8'h00, 1'b0});
    vecs.push_back('{8'h00, AC_LD, 16'h0000, 16'h1234, 3'd0, 16'h0000, 12'h123, 12'h123, 16'hB7A5, 16'h1234, 16'hB7A5, 16'h0000, 8'h00, 1'b0});
    vecs.push_back('{8'h10, OUTR_LD, 16'h0000, 16'h0000, 3'd4, 16'h1234, 12'h123, 12'h123, 16'hB7A5, 16'h1234, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h00, AC_LD, 16'h0000, 16'h0FFF, 3'd0, 16'h0000, 12'h123, 12'h123, 16'hB7A5, 16'h0FFF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h10, PC_LD, 16'h0000, 16'h0000, 3'd4, 16'h0FFF, 12'h123, 12'hFFF, 16'hB7A5, 16'h0FFF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h00, PC_INR, 16'h0000, 16'h0000, 3'd0, 16'h0000, 12'h123, 12'h000, 16'hB7A5, 16'h0FFF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h10, PC_CLR | PC_LD | PC_INR, 16'h0000, 16'h0000, 3'd4, 16'h0FFF, 12'h123, 12'h000, 16'hB7A5, 16'h0FFF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h00, AC_LD | AC_INR, 16'h0000, 16'h00FF, 3'd0, 16'h0000, 12'h123, 12'h000, 16'hB7A5, 16'h00FF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h10, AC_LD | TR_LD, 16'h0000, 16'h5A5A, 3'd4, 16'h00FF, 12'h123, 12'h000, 16'hB7A5, 16'h5A5A, 16'hB7A5, 16'h00FF, 8'h34, 1'b0});
    vecs.push_back('{8'h10, TR_LD, 16'h0000, 16'h0000, 3'd4, 16'h5A5A, 12'h123, 12'h000, 16'hB7A5, 16'h5A5A, 16'hB7A5, 16'h5A5A, 8'h34, 1'b0});
    vecs.push_back('{8'h40, TR_LD | TR_INR, 16'h0000, 16'h0000, 3'd6, 16'h5A5A, 12'h123, 12'h000, 16'hB7A5, 16'h5A5A, 16'hB7A5, 16'h5A5A, 8'h34, 1'b0});
    vecs.push_back('{8'h00, TR_INR, 16'h0000, 16'h0000, 3'd0, 16'h0000, 12'h123, 12'h000, 16'hB7A5, 16'h5A5A, 16'hB7A5, 16'h5A5B, 8'h34, 1'b0});
    vecs.push_back('{8'h00, AC_LD, 16'h0000, 16'hFFFF, 3'd0, 16'h0000, 12'h123, 12'h000, 16'hB7A5, 16'hFFFF, 16'hB7A5, 16'h5A5B, 8'h34, 1'b0});
    vecs.push_back('{8'h10, DR_LD | AR_LD | TR_LD, 16'h0000, 16'h0000, 3'd4, 16'hFFFF, 12'hFFF, 12'h000, 16'hFFFF, 16'hFFFF, 16'hB7A5, 16'hFFFF, 8'h34, 1'b0});
    vecs.push_back('{8'h00, DR_INR | AR_INR | TR_INR | AC_INR, 16'h0000, 16'h0000, 3'd0, 16'h0000, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h00, AC_LD, 16'h0000, 16'h0010, 3'd0, 16'h0000, 12'h000, 12'h000, 16'h0000, 16'h0010, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h10, AR_LD | AC_LD, 16'h0000, 16'hBEEF, 3'd4, 16'h0010, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b0});
    vecs.push_back('{8'h12, NO_CTL, 16'h0000, 16'h0000, 3'd4, 16'hBEEF, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b1});
    vecs.push_back('{8'h02, AR_CLR, 16'h0000, 16'h0000, 3'd1, 16'h0010, 12'h000, 12'h000, 16'h0000, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b1});
    vecs.push_back('{8'hFE, PC_LD, 16'h1357, 16'h0000, 3'd7, 16'h1357, 12'h000, 12'h357, 16'h0000, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b1});
    vecs.push_back('{8'h20, DR_LD, 16'h0000, 16'h0000, 3'd5, 16'hB7A5, 12'h000, 12'h357, 16'hB7A5, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b1});
    vecs.push_back('{8'h08, DR_CLR | DR_LD, 16'h0000, 16'h0000, 3'd3, 16'hB7A5, 12'h000, 12'h357, 16'h0000, 16'hBEEF, 16'hB7A5, 16'h0000, 8'h34, 1'b1});
    vecs.push_back('{8'h00, TR_CLR | AC_CLR | AC_LD, 16'h0000, 16'h1111, 3'd0, 16'h0000, 12'h000, 12'h357, 16'h0000, 16'h0000, 16'hB7A5, 16'h0000, 8'h34, 1'b1});

    zero_v = '{8'h00, NO_CTL, 16'h0000, 16'h0000, 3'd0, 16'h0000, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0};

    // Power-on reset
    drive(8'h00, NO_CTL, 16'h0000, 16'h0000);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_regs("por", zero_v);
    check_comb("por", 3'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // PC as both source and destination keeps its value; ld beats inr
    h = vecs[vecs.size() - 1];
    h.x = 8'h04; h.ctl = PC_LD | PC_INR; h.sel = 3'd2; h.bus = 16'h0357;
    step("self_pc", h);

    h.x = 8'h00; h.ctl = AR_INR | TR_INR | DR_INR; h.sel = 3'd0; h.bus = 16'h0000;
    h.ar = 12'h001; h.tr = 16'h0001; h.dr = 16'h0001;
    step("pre_rst", h);

    // Reset dominates every control and suppresses contention capture
    @(negedge clk);
    drive(8'hFE, 17'h1FFFF, 16'hFFFF, 16'hFFFF);
    reset = 1'b1;
    #1 check_comb("rst_dom", 3'd7, 16'hFFFF);
    @(posedge clk);
    #1 check_regs("rst_dom", zero_v);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h00, NO_CTL, 16'h0000, 16'h0000);
    #1 check_comb("post_rst", 3'd0, 16'h0000);
    @(posedge clk);
    #1 check_regs("post_rst", zero_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
